mux3_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 32-bit three-input datapath mux between three requesters. It owns the 2-bit select of an internal mux3_32b instance and a one-hot grant back to the requesters. An optional hold limit forces rotation so that a streaming requester cannot starve the others. It sits in front of any shared 32-bit write/bus port fed from three sources.

---
 rtl/mux3_rr_arbiter_pkg.sv | 71 +++++++
 rtl/mux3_rr_arbiter_if.sv | 38 +++
 rtl/mux3_rr_arbiter_mux.sv | 24 ++
 rtl/mux3_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_mux3_rr_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux3_rr_arbiter_pkg.sv
// Shared definitions for the three-source round-robin arbiter:
// select encodings, FSM states and the rotation helper used to pick
// the next owner of the shared mux.
package mux3_rr_arbiter_pkg;

   localparam logic [1:0] SEL_IN0 = 2'b00;
   localparam logic [1:0] SEL_IN1 = 2'b01;
   localparam logic [1:0] SEL_IN2 = 2'b10;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Result of a priority search: whether anyone qualified and who.
   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } pick_t;

   // Next index on the 0 -> 1 -> 2 -> 0 ring; 3 is never a legal index
   // and simply maps back onto the ring.
   function automatic logic [1:0] ring_next(input logic [1:0] idx);
      logic [1:0] nxt;
      case (idx)
         SEL_IN0: nxt = SEL_IN1;
         SEL_IN1: nxt = SEL_IN2;
         default: nxt = SEL_IN0;
      endcase
      return nxt;
   endfunction

   // Scan the requests starting just after the last owner and return the
   // first one that is set. The last owner itself is checked last.
   function automatic pick_t pick_next(input logic [2:0] req,
                                       input logic [1:0] last);
      pick_t      p;
      logic [1:0] c1;
      logic [1:0] c2;
      logic [1:0] c3;
      c1      = ring_next(last);
      c2      = ring_next(c1);
      c3      = ring_next(c2);
      p.found = 1'b0;
      p.idx   = SEL_IN0;
      if (req[c1]) begin
         p.found = 1'b1;
         p.idx   = c1;
      end else if (req[c2]) begin
         p.found = 1'b1;
         p.idx   = c2;
      end else if (req[c3]) begin
         p.found = 1'b1;
         p.idx   = c3;
      end
      return p;
   endfunction

   // One-hot form of a mux select; select 3 has no source and gives zero.
   function automatic logic [2:0] sel_to_onehot(input logic [1:0] idx);
      logic [2:0] oh;
      case (idx)
         SEL_IN0: oh = 3'b001;
         SEL_IN1: oh = 3'b010;
         SEL_IN2: oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/mux3_rr_arbiter_if.sv
// Bundle between the three requesters and the arbiter: requests and
// source data in, grant/select/muxed data out.
interface mux3_rr_arbiter_if #(
   parameter int WIDTH = 32
);
   logic [2:0]       req;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [2:0]       gnt;
   logic [1:0]       sel;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;

   // Requester side drives requests and data, observes the grant.
   modport master (
      output req,
      output in0,
      output in1,
      output in2,
      input  gnt,
      input  sel,
      input  out_data,
      input  out_valid
   );

   // Arbiter side.
   modport slave (
      input  req,
      input  in0,
      input  in1,
      input  in2,
      output gnt,
      output sel,
      output out_data,
      output out_valid
   );
endinterface

// File: rtl/mux3_rr_arbiter_mux.sv
// Plain three-input datapath mux. Control 11 has no source behind it and
// produces zero so the output is never undefined.
module mux3_32b #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [1:0]       control,
   output logic [WIDTH-1:0] out
);

   // Pure combinational select of one source onto the output.
   always_comb begin
      out = '0;
      case (control)
         2'b00:   out = in0;
         2'b01:   out = in1;
         2'b10:   out = in2;
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared three-input mux.
// The owner is remembered in last_q, so the rotation always restarts just
// after whoever held the mux most recently. A hold counter forces the
// owner off after MAX_HOLD cycles when someone else is waiting.
module mux3_rr_arbiter
   import mux3_rr_arbiter_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MAX_HOLD = 4
) (
   input  logic            clock,
   input  logic            reset,
   mux3_rr_arbiter_if.slave bus
);

   localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
   localparam bit HOLD_ENABLED = (MAX_HOLD != 0);

   state_t            state_q;
   state_t            state_d;
   logic [2:0]        gnt_q;
   logic [2:0]        gnt_d;
   logic [1:0]        sel_q;
   logic [1:0]        sel_d;
   logic [1:0]        last_q;
   logic [1:0]        last_d;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic [HOLD_W-1:0] hold_cnt_d;
   logic              out_valid_q;
   logic              out_valid_d;

   logic [2:0]        contenders;
   pick_t             pick;
   logic              owner_req;
   logic              hold_expired;

   // Candidates for the next grant: in GRANT the current owner is excluded,
   // so a release-and-rerequest or a forced rotation always moves on.
   always_comb begin
      contenders = bus.req;
      if (state_q == GRANT) begin
         contenders = bus.req & ~sel_to_onehot(last_q);
      end
   end

   assign pick         = pick_next(contenders, last_q);
   assign owner_req    = |(bus.req & sel_to_onehot(last_q));
   assign hold_expired = HOLD_ENABLED && (hold_cnt_q == HOLD_LIMIT);

   // Next-state logic: decide whether to grant, keep, rotate or go idle.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      sel_d       = sel_q;
      last_d      = last_q;
      hold_cnt_d  = hold_cnt_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (pick.found) begin
               state_d     = GRANT;
               gnt_d       = sel_to_onehot(pick.idx);
               sel_d       = pick.idx;
               last_d      = pick.idx;
               hold_cnt_d  = HOLD_ONE;
               out_valid_d = 1'b1;
            end
         end

         GRANT: begin
            if (!owner_req) begin
               if (pick.found) begin
                  gnt_d       = sel_to_onehot(pick.idx);
                  sel_d       = pick.idx;
                  last_d      = pick.idx;
                  hold_cnt_d  = HOLD_ONE;
                  out_valid_d = 1'b1;
               end else begin
                  state_d     = IDLE;
                  gnt_d       = 3'b000;
                  out_valid_d = 1'b0;
               end
            end else if (hold_expired && pick.found) begin
               gnt_d       = sel_to_onehot(pick.idx);
               sel_d       = pick.idx;
               last_d      = pick.idx;
               hold_cnt_d  = HOLD_ONE;
               out_valid_d = 1'b1;
            end else if (HOLD_ENABLED && (hold_cnt_q < HOLD_LIMIT)) begin
               hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
         end

         default: begin
            state_d     = IDLE;
            gnt_d       = 3'b000;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State registers; reset leaves last on source 2 so source 0 wins first.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_q       <= 3'b000;
         sel_q       <= SEL_IN0;
         last_q      <= SEL_IN2;
         hold_cnt_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         sel_q       <= sel_d;
         last_q      <= last_d;
         hold_cnt_q  <= hold_cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.sel       = sel_q;
   assign bus.out_valid = out_valid_q;

   mux3_32b #(
      .WIDTH (WIDTH)
   ) u_mux (
      .in0     (bus.in0),
      .in1     (bus.in1),
      .in2     (bus.in2),
      .control (sel_q),
      .out     (bus.out_data)
   );

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Testbench for mux3_rr_arbiter: table-driven vectors, hand sequences for
// hold limit / reset / unlimited-hold corners, then randomized traffic
// compared against a queue-based model of the rotation rules.
module tb_mux3_rr_arbiter;

   logic clock;
   logic reset;

   int check_count;
   int error_count;

   mux3_rr_arbiter_if #(.WIDTH(32)) bus4 ();
   mux3_rr_arbiter_if #(.WIDTH(32)) bus0 ();

   mux3_rr_arbiter #(.WIDTH(32), .MAX_HOLD(4)) dut4 (
      .clock (clock),
      .reset (reset),
      .bus   (bus4)
   );

   mux3_rr_arbiter #(.WIDTH(32), .MAX_HOLD(0)) dut0 (
      .clock (clock),
      .reset (reset),
      .bus   (bus0)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]  req;
      logic [2:0]  exp_gnt;
      logic [1:0]  exp_sel;
      logic        exp_valid;
      logic [31:0] exp_data;
   } vec_t;

   localparam logic [31:0] D0 = 32'h55555555;
   localparam logic [31:0] D1 = 32'h0000FFFF;
   localparam logic [31:0] D2 = 32'hFFFF0000;

   // Reference model state: owner -1 means idle.
   int m_owner;
   int m_last;
   int m_held;
   int m_sel;
   int m_max;

   task automatic check_val(input string name, input logic [31:0] got,
                            input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic checkOutput(input string name, input logic [2:0] gnt,
                              input logic [1:0] sel, input logic valid,
                              input logic [31:0] data);
      check_val({name, ".gnt"}, 32'(bus4.gnt), 32'(gnt));
      check_val({name, ".sel"}, 32'(bus4.sel), 32'(sel));
      check_val({name, ".valid"}, 32'(bus4.out_valid), 32'(valid));
      check_val({name, ".data"}, bus4.out_data, data);
   endtask

   // Drive requests between edges, then let one rising edge sample them.
   task automatic applyStimulus(input logic [2:0] req);
      @(negedge clock);
      bus4.req = req;
      @(posedge clock);
      #1;
   endtask

   function automatic void model_reset();
      m_owner = -1;
      m_last  = 2;
      m_held  = 0;
      m_sel   = 0;
   endfunction

   function automatic void model_grant(input int i);
      m_owner = i;
      m_last  = i;
      m_held  = 1;
      m_sel   = i;
   endfunction

   // One rising edge of the arbiter as described by its rotation rules.
   function automatic void model_step(input logic [2:0] r);
      int waiting[$];
      for (int k = 1; k <= 3; k++) begin
         int i;
         i = (m_last + k) % 3;
         if (r[i] && i != m_owner) waiting.push_back(i);
      end
      if (m_owner < 0) begin
         if (waiting.size() > 0) model_grant(waiting[0]);
      end else if (!r[m_owner]) begin
         if (waiting.size() > 0) model_grant(waiting[0]);
         else m_owner = -1;
      end else if (m_max != 0 && m_held >= m_max && waiting.size() > 0) begin
         model_grant(waiting[0]);
      end else if (m_max != 0 && m_held < m_max) begin
         m_held++;
      end
   endfunction

   vec_t vecs[$];

   initial begin
      logic [31:0] srcs[3];
      logic [2:0]  r;
      check_count = 0;
      error_count = 0;
      m_max = 4;
      model_reset();

      bus4.req = 3'b000;
      bus4.in0 = D0;
      bus4.in1 = D1;
      bus4.in2 = D2;
      bus0.req = 3'b000;
      bus0.in0 = D0;
      bus0.in1 = D1;
      bus0.in2 = D2;

      reset = 1'b1;
      #12;
      checkOutput("reset", 3'b000, 2'b00, 1'b0, D0);
      check_val("reset.dut0.gnt", 32'(bus0.gnt), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Basic grant, idle, release hand-off without a bubble.
      vecs.push_back('{3'b001, 3'b001, 2'b00, 1'b1, D0});
      vecs.push_back('{3'b000, 3'b000, 2'b00, 1'b0, D0});
      vecs.push_back('{3'b010, 3'b010, 2'b01, 1'b1, D1});
      vecs.push_back('{3'b110, 3'b010, 2'b01, 1'b1, D1});
      vecs.push_back('{3'b100, 3'b100, 2'b10, 1'b1, D2});
      vecs.push_back('{3'b000, 3'b000, 2'b10, 1'b0, D2});
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].req);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_sel,
                     vecs[i].exp_valid, vecs[i].exp_data);
      end

      // All three streaming: each keeps the mux for four cycles in turn.
      srcs[0] = D0;
      srcs[1] = D1;
      srcs[2] = D2;
      for (int n = 0; n < 13; n++) begin
         int o;
         o = (n / 4) % 3;
         applyStimulus(3'b111);
         checkOutput($sformatf("rot%0d", n), 3'(1 << o), 2'(o), 1'b1, srcs[o]);
      end
      applyStimulus(3'b000);
      checkOutput("rot_idle", 3'b000, 2'b00, 1'b0, D0);

      // A lone requester is never forced off.
      for (int n = 0; n < 10; n++) begin
         applyStimulus(3'b010);
         checkOutput($sformatf("solo%0d", n), 3'b010, 2'b01, 1'b1, D1);
      end
      applyStimulus(3'b000);
      checkOutput("solo_idle", 3'b000, 2'b01, 1'b0, D1);

      // Reset between edges clears the outputs without waiting for a clock.
      applyStimulus(3'b100);
      checkOutput("pre_rst", 3'b100, 2'b10, 1'b1, D2);
      #1 reset = 1'b1;
      #1;
      checkOutput("mid_rst", 3'b000, 2'b00, 1'b0, D0);
      #1 reset = 1'b0;
      applyStimulus(3'b110);
      checkOutput("post_rst", 3'b010, 2'b01, 1'b1, D1);
      applyStimulus(3'b000);

      // Unlimited hold build: source 0 keeps the mux until it lets go.
      @(negedge clock);
      bus0.req = 3'b001;
      @(posedge clock);
      #1;
      check_val("nohold.first", 32'(bus0.gnt), 32'b001);
      for (int n = 0; n < 10; n++) begin
         @(negedge clock);
         bus0.req = 3'b011;
         @(posedge clock);
         #1;
         check_val($sformatf("nohold%0d", n), 32'(bus0.gnt), 32'b001);
      end
      @(negedge clock);
      bus0.req = 3'b010;
      @(posedge clock);
      #1;
      check_val("nohold.handoff.gnt", 32'(bus0.gnt), 32'b010);
      check_val("nohold.handoff.data", bus0.out_data, D1);
      @(negedge clock);
      bus0.req = 3'b000;

      // Randomized traffic against the model, with occasional resets.
      @(negedge clock);
      reset = 1'b1;
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clock);
         if ($urandom_range(0, 99) == 0) begin
            reset = 1'b1;
            model_reset();
            #1 reset = 1'b0;
         end
         for (int b = 0; b < 3; b++) r[b] = ($urandom_range(0, 9) < 6);
         bus4.req = r;
         bus4.in0 = $urandom;
         bus4.in1 = $urandom;
         bus4.in2 = $urandom;
         srcs[0] = bus4.in0;
         srcs[1] = bus4.in1;
         srcs[2] = bus4.in2;
         model_step(r);
         @(posedge clock);
         #1;
         checkOutput($sformatf("rnd%0d", n),
                     (m_owner < 0) ? 3'b000 : 3'(1 << m_owner),
                     2'(m_sel), (m_owner >= 0), srcs[m_sel]);
      end

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
